// File: rtl/sm_adder_pkg.sv
// sm_adder_pkg: shared types and default widths for the sign-magnitude
// ROM adder controller (FSM state encoding, operand/address/sum widths).
package sm_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } state_t;

   localparam int DEF_MAG_WIDTH      = 3;
   localparam int DEF_ROM_DATA_WIDTH = 8;
   localparam int OP_WIDTH           = DEF_MAG_WIDTH + 1;
   localparam int ADDR_WIDTH         = 2 * OP_WIDTH;
   localparam int SUM_WIDTH          = DEF_MAG_WIDTH + 2;

endpackage

// File: rtl/sm_rom_adder_ctrl_if.sv
// sm_rom_adder_ctrl_if: operand and result valid/ready handshakes.
// master = operand source / result consumer, slave = the controller.
interface sm_rom_adder_ctrl_if #(
   parameter int MAG_WIDTH = 3
);
   logic                 in_valid_i;
   logic                 in_ready_o;
   logic [MAG_WIDTH:0]   a_i;
   logic [MAG_WIDTH:0]   b_i;
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [MAG_WIDTH+1:0] sum_o;

   modport master (
      output in_valid_i, a_i, b_i, out_ready_i,
      input  in_ready_o, out_valid_o, sum_o
   );

   modport slave (
      input  in_valid_i, a_i, b_i, out_ready_i,
      output in_ready_o, out_valid_o, sum_o
   );
endinterface

// File: rtl/sm_rom_adder_ctrl.sv
// sm_rom_adder_ctrl: accepts a sign-magnitude operand pair, addresses an
// external 1-cycle adder ROM with {a, b}, normalises the returned sum
// (-0 -> +0) and holds it on a valid/ready result port.
// Ports: clk_i, rst_ni (async, active low), bus (operand/result
// handshakes), rom_addr_o / rom_data_i (ROM), op_count_o (results done).
module sm_rom_adder_ctrl
   import sm_adder_pkg::*;
#(
   parameter int MAG_WIDTH      = 3,
   parameter int ROM_DATA_WIDTH = 8,
   parameter int CNT_WIDTH      = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   sm_rom_adder_ctrl_if.slave          bus,
   output logic [2*(MAG_WIDTH+1)-1:0]  rom_addr_o,
   input  logic [ROM_DATA_WIDTH-1:0]   rom_data_i,
   output logic [CNT_WIDTH-1:0]        op_count_o
);

   localparam int OpW   = MAG_WIDTH + 1;
   localparam int AddrW = 2 * OpW;
   localparam int SumW  = MAG_WIDTH + 2;

   state_t             state_q, state_d;
   logic [AddrW-1:0]   addr_q, addr_d;
   logic [SumW-1:0]    sum_q, sum_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [MAG_WIDTH:0] rom_mag;
   logic               rom_sign;
   logic [SumW-1:0]    rom_norm;

   // A zero magnitude always carries a positive sign.
   assign rom_mag  = rom_data_i[MAG_WIDTH:0];
   assign rom_sign = rom_data_i[MAG_WIDTH+1] & (|rom_mag);
   assign rom_norm = {rom_sign, rom_mag};

   if (ROM_DATA_WIDTH > SumW) begin : g_rom_hi
      logic unused_rom_hi;
      assign unused_rom_hi = ^rom_data_i[ROM_DATA_WIDTH-1:SumW];
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid_i) begin
               addr_d  = {bus.a_i, bus.b_i};
               state_d = ADDR;
            end
         end
         ADDR: state_d = DATA;
         DATA: begin
            sum_d   = rom_norm;
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready_i) begin
               cnt_d   = cnt_q + CNT_WIDTH'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready_o  = (state_q == IDLE);
   assign bus.out_valid_o = (state_q == HOLD);
   assign bus.sum_o       = sum_q;
   assign rom_addr_o      = addr_q;
   assign op_count_o      = cnt_q;

endmodule

// File: tb/tb_sm_rom_adder_ctrl.sv
// tb_sm_rom_adder_ctrl: bench for sm_rom_adder_ctrl with a behavioural
// 1-cycle adder ROM and a transaction-level reference model.
module tb_sm_rom_adder_ctrl;
   import sm_adder_pkg::*;

   localparam int MW   = DEF_MAG_WIDTH;
   localparam int RW   = DEF_ROM_DATA_WIDTH;
   localparam int OW   = OP_WIDTH;
   localparam int AW   = ADDR_WIDTH;
   localparam int SW   = SUM_WIDTH;
   localparam int MAGS = MW + 1;
   localparam int CW   = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] rom_addr;
   logic [RW-1:0] rom_data = '0;
   logic [CW-1:0] op_count;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;
   int mode     = 2;

   sm_rom_adder_ctrl_if #(.MAG_WIDTH(MW)) bus ();

   sm_rom_adder_ctrl #(
      .MAG_WIDTH      (MW),
      .ROM_DATA_WIDTH (RW),
      .CNT_WIDTH      (CW)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .bus        (bus),
      .rom_addr_o (rom_addr),
      .rom_data_i (rom_data),
      .op_count_o (op_count)
   );

   always #5 clk = ~clk;

   // Sign-magnitude adder ROM; equal magnitudes keep A's sign (may give -0).
   function automatic logic [RW-1:0] rom_word(input logic [AW-1:0] ad,
                                              input logic [RW-1:0] junk);
      logic sa, sb, sg;
      int   ma, mb, m;
      sa = ad[AW-1];
      sb = ad[OW-1];
      ma = int'(ad[AW-2:OW]);
      mb = int'(ad[MW-1:0]);
      if (sa == sb) begin
         sg = sa; m = ma + mb;
      end else if (ma >= mb) begin
         sg = sa; m = ma - mb;
      end else begin
         sg = sb; m = mb - ma;
      end
      rom_word = junk;
      rom_word[SW-1:0] = {sg, MAGS'(m)};
   endfunction

   always @(posedge clk) rom_data <= rom_word(rom_addr, RW'($urandom));

   // Reference sum from signed integer arithmetic.
   function automatic logic [SW-1:0] ref_sum(input logic [OW-1:0] a,
                                             input logic [OW-1:0] b);
      int va, vb, s;
      va = a[OW-1] ? -int'(a[MW-1:0]) : int'(a[MW-1:0]);
      vb = b[OW-1] ? -int'(b[MW-1:0]) : int'(b[MW-1:0]);
      s  = va + vb;
      return {(s < 0), MAGS'((s < 0) ? -s : s)};
   endfunction

   // Transaction model: one operation in flight, result visible 3 cycles
   // after the accepting cycle, counted when the consumer takes it.
   int            cyc;
   bit            busy;
   int            t_acc;
   logic [AW-1:0] m_addr;
   logic [SW-1:0] cur_sum, last_sum;
   int            m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; busy = 1'b0; t_acc = 0;
         m_addr = '0; cur_sum = '0; last_sum = '0; m_cnt = 0;
      end else begin
         if (!busy) begin
            if (bus.in_valid_i) begin
               busy    = 1'b1;
               t_acc   = cyc;
               m_addr  = {bus.a_i, bus.b_i};
               cur_sum = ref_sum(bus.a_i, bus.b_i);
            end
         end else if ((cyc - t_acc) >= 3 && bus.out_ready_i) begin
            busy     = 1'b0;
            last_sum = cur_sum;
            m_cnt    = (m_cnt + 1) % (1 << CW);
         end
         cyc++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         logic ev;
         ev = busy && ((cyc - t_acc) >= 3);
         chk("in_ready", 32'(bus.in_ready_o), 32'(!busy));
         chk("out_valid", 32'(bus.out_valid_o), 32'(ev));
         chk("sum", 32'(bus.sum_o), 32'(ev ? cur_sum : last_sum));
         chk("rom_addr", 32'(rom_addr), 32'(m_addr));
         chk("op_count", 32'(op_count), 32'(m_cnt));
      end
   end

   // Result consumer: 0 random, 1 always ready, 2 driven by main thread.
   always @(negedge clk) begin
      if (mode == 0) bus.out_ready_i = 1'($urandom_range(0, 1));
      else if (mode == 1) bus.out_ready_i = 1'b1;
   end

   // Called at a falling edge; returns at the falling edge after accept.
   task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b);
      int n = 0;
      bus.in_valid_i = 1'b1;
      bus.a_i = a;
      bus.b_i = b;
      while (!bus.in_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_timeout", 32'(n < 100), 32'd1);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      bus.a_i = OW'($urandom);
      bus.b_i = OW'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!bus.out_valid_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", 32'(n < 50), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!bus.in_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", 32'(n < 50), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
      chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
      chk({tag, "_sum"}, 32'(bus.sum_o), 32'd0);
      chk({tag, "_op_count"}, 32'(op_count), 32'd0);
   endtask

   int lat;
   int cnt0;
   int acc [5];
   logic [CW-1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   initial begin
      rst_n = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.a_i         = '0;
      bus.b_i         = '0;
      bus.out_ready_i = 1'b0;
      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // Positive sum and latency
      mode = 1;
      send(4'b0011, 4'b0010);
      chk("t1_addr", 32'(rom_addr), 32'h32);
      wait_valid(lat);
      chk("t1_latency", 32'(lat), 32'd2);
      chk("t1_sum", 32'(bus.sum_o), 32'b00101);

      // Mixed signs
      send(4'b1101, 4'b0010);
      wait_valid(lat);
      chk("t2_sum", 32'(bus.sum_o), 32'b10011);

      // Negative zero from the ROM
      send(4'b1101, 4'b0101);
      wait_valid(lat);
      chk("t3_sum", 32'(bus.sum_o), 32'b00000);

      // Backpressure with new operands waiting
      @(negedge clk);
      mode = 2;
      bus.out_ready_i = 1'b0;
      send(4'b0001, 4'b0001);
      wait_valid(lat);
      bus.in_valid_i = 1'b1;
      bus.a_i = 4'b0110;
      bus.b_i = 4'b1011;
      cnt0 = int'(op_count);
      for (int k = 0; k < 5; k++) begin
         chk("t4_sum", 32'(bus.sum_o), 32'b00010);
         chk("t4_in_ready", 32'(bus.in_ready_o), 32'd0);
         chk("t4_count", 32'(op_count), 32'(cnt0));
         @(negedge clk);
      end
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      bus.out_ready_i = 1'b0;
      chk("t4_in_ready_after", 32'(bus.in_ready_o), 32'd1);
      chk("t4_count_after", 32'(op_count), 32'((cnt0 + 1) % 4));
      @(negedge clk);
      chk("t4_new_addr", 32'(rom_addr), 32'h6B);
      bus.in_valid_i = 1'b0;
      mode = 1;
      wait_idle();

      // Reset while in DATA
      send(4'b0111, 4'b0111);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("t5");
      @(negedge clk);
      rst_n = 1'b1;
      send(4'b1010, 4'b0011);
      wait_valid(lat);
      chk("t5_sum", 32'(bus.sum_o), 32'b00001);
      wait_idle();

      // Counter wrap with back-to-back operations
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         acc[i] = cyc;
         send(OW'($urandom), OW'($urandom));
         repeat (3) @(negedge clk);
         chk("t6_count", 32'(op_count), 32'(exp_seq[i]));
         chk("t6_ready", 32'(bus.in_ready_o), 32'd1);
         if (i > 0) chk("t6_spacing", 32'(acc[i] - acc[i-1]), 32'd4);
      end

      // Random traffic
      mode = 0;
      for (int i = 0; i < 150; i++) begin
         repeat ($urandom_range(0, 3)) begin
            bus.a_i = OW'($urandom);
            bus.b_i = OW'($urandom);
            @(negedge clk);
         end
         send(OW'($urandom), OW'($urandom));
      end
      mode = 1;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
